// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and the SECDED Hamming(16,11) encode function
//               used by the encoder engine and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

  localparam int MSG_W = 11;
  localparam int CW_W  = 16;

  // Parity bit positions inside the 16-bit codeword
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_CAP   = 3'd3,
    ST_WR_LO = 3'd4,
    ST_WR_HI = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic [7:0] msw;
    logic [7:0] lsw;
  } codeword_t;

  // msg[k-1] holds message bit bk (b1..b11)
  function automatic logic [CW_W-1:0] hamm_encode(input logic [MSG_W-1:0] msg);
    logic [CW_W-1:0] cw;
    cw           = '0;
    cw[15:9]     = msg[10:4];
    cw[7:5]      = msg[3:1];
    cw[3]        = msg[0];
    cw[P8_POS]   = ^msg[10:4];
    cw[P4_POS]   = ^{msg[10:7], msg[3:1]};
    cw[P2_POS]   = ^{msg[10:9], msg[6:5], msg[3:2], msg[0]};
    cw[P1_POS]   = ^{msg[10], msg[8], msg[6], msg[4], msg[3], msg[1], msg[0]};
    // Overall parity covers every other codeword bit
    cw[P0_POS]   = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_enc_core.sv
// ============================================================================
// Module      : hamming_enc_core
// Description : Combinational 11-bit to 16-bit SECDED Hamming encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0] i_msg,
  output logic [CW_W-1:0]  o_codeword
);

  // Pure function wrapper so the engine and any consumer share one encoding
  assign o_codeword = hamm_encode(i_msg);

endmodule

`default_nettype wire

// File: rtl/hamming_enc_engine.sv
// ============================================================================
// Module      : hamming_enc_engine
// Description : Memory-mastering SECDED Hamming(16,11) encoder. On Start it
//               reads NUM_MSG two-byte messages at SRC_BASE, encodes them and
//               writes two-byte codewords at DST_BASE, then raises Ack.
//               Optional macro ERR_INJECT_EN adds InjMask, XORed into every
//               codeword before it is written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
`ifdef ERR_INJECT_EN
  input  logic [15:0]       InjMask,
`endif
  input  logic              Start,
  output logic              Ack,
  output logic              Busy,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData
);

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  codeword_t         cw_q, cw_d;
  logic [15:0]       inj_q, inj_d;
  logic [CW_W-1:0]   enc_cw;
  logic [ADDR_W-1:0] msg_off;
  logic              unused_rd_hi;

  // Upper five bits of the message MSW carry no data
  assign unused_rd_hi = ^MemRdData[7:3];

  // Byte offset of message/codeword i (wraps modulo 2^ADDR_W)
  assign msg_off = ADDR_W'(idx_q) << 1;

  // MSW arrives on MemRdData during CAP, so encode straight from the bus
  hamming_enc_core u_core (
    .i_msg      ({MemRdData[2:0], lo_q}),
    .o_codeword (enc_cw)
  );

  // State and datapath registers; reset aborts any run in progress
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      cw_q    <= '0;
      inj_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      cw_q    <= cw_d;
      inj_q   <= inj_d;
    end
  end

  // Next-state, datapath updates and memory-port outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    cw_d      = cw_q;
    inj_d     = inj_q;
    Ack       = 1'b0;
    Busy      = 1'b0;
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        Ack = (state_q == ST_DONE);
        if (Start) begin
          state_d = ST_RD_LO;
          idx_d   = '0;
`ifdef ERR_INJECT_EN
          inj_d   = InjMask;
`else
          inj_d   = '0;
`endif
        end
      end
      ST_RD_LO: begin
        Busy    = 1'b1;
        MemAddr = SRC_A + msg_off;
        state_d = ST_RD_HI;
      end
      ST_RD_HI: begin
        Busy    = 1'b1;
        MemAddr = SRC_A + msg_off + ONE_A;
        lo_d    = MemRdData;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        Busy    = 1'b1;
        cw_d    = codeword_t'(enc_cw ^ inj_q);
        state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        Busy      = 1'b1;
        MemAddr   = DST_A + msg_off;
        MemWrEn   = 1'b1;
        MemWrData = cw_q.lsw;
        state_d   = ST_WR_HI;
      end
      ST_WR_HI: begin
        Busy      = 1'b1;
        MemAddr   = DST_A + msg_off + ONE_A;
        MemWrEn   = 1'b1;
        MemWrData = cw_q.msw;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RD_LO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_enc_engine.sv
// ============================================================================
// Module      : tb_hamming_enc_engine
// Description : Self-checking bench for hamming_enc_engine with a byte-wide
//               synchronous-read memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hamming_enc_engine;

  localparam int ADDR_W    = 8;
  localparam int NUM_MSG   = 15;
  localparam int SRC_BASE  = 0;
  localparam int DST_BASE  = 30;
  localparam int ACK_EDGES = 5 * NUM_MSG + 1;
  localparam int BOUND     = ACK_EDGES + 50;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic              Ack, Busy, MemWrEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemWrData;
  logic [7:0]        MemRdData = 8'h00;
`ifdef ERR_INJECT_EN
  logic [15:0]       InjMask = 16'h0000;
`endif

  always #5 Clk = ~Clk;

  hamming_enc_engine #(
    .ADDR_W(ADDR_W), .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
`ifdef ERR_INJECT_EN
    .InjMask   (InjMask),
`endif
    .Start     (Start),
    .Ack       (Ack),
    .Busy      (Busy),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  // Memory model: bench load port has priority, DUT writes otherwise
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_a = 8'h00, tb_d = 8'h00;
  always @(posedge Clk) begin
    if (tb_we) mem[tb_a] <= tb_d;
    else if (MemWrEn) mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
  end

  int total = 0;
  int bad   = 0;
  int stray = 0;

  // Writes outside the destination window or while not busy
  always @(negedge Clk) begin
    if (Reset_n && MemWrEn &&
        (int'(MemAddr) < DST_BASE || int'(MemAddr) > DST_BASE + 2*NUM_MSG - 1 || !Busy))
      stray++;
  end

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] exp_lo;
    logic [7:0] exp_hi;
  } vec_t;
  vec_t vecs [7];

  logic [7:0] src_lo [NUM_MSG];
  logic [7:0] src_hi [NUM_MSG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference written from the b1..b11 bit numbering
  function automatic logic [15:0] model(input logic [7:0] lo, input logic [7:0] hi);
    logic b [1:11];
    logic p8, p4, p2, p1, p0;
    logic [7:0] msw, lsw;
    for (int k = 1; k <= 8; k++) b[k] = lo[k-1];
    b[9] = hi[0]; b[10] = hi[1]; b[11] = hi[2];
    p8 = b[11]^b[10]^b[9]^b[8]^b[7]^b[6]^b[5];
    p4 = b[11]^b[10]^b[9]^b[8]^b[4]^b[3]^b[2];
    p2 = b[11]^b[10]^b[7]^b[6]^b[4]^b[3]^b[1];
    p1 = b[11]^b[9]^b[7]^b[5]^b[4]^b[2]^b[1];
    msw = {b[11], b[10], b[9], b[8], b[7], b[6], b[5], p8};
    lsw = {b[4], b[3], b[2], p4, b[1], p2, p1, 1'b0};
    p0 = ^{msw, lsw};
    lsw[0] = p0;
    return {msw, lsw};
  endfunction

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge Clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic load_src();
    for (int k = 0; k < NUM_MSG; k++) begin
      load_byte(8'(SRC_BASE + 2*k), src_lo[k]);
      load_byte(8'(SRC_BASE + 2*k + 1), src_hi[k]);
    end
  endtask

  task automatic fill_dst(input logic [7:0] v);
    for (int j = 0; j < 2*NUM_MSG; j++) load_byte(8'(DST_BASE + j), v);
  endtask

  task automatic randomize_src();
    for (int k = 0; k < NUM_MSG; k++) begin
      src_lo[k] = 8'($urandom);
      src_hi[k] = 8'($urandom);
    end
  endtask

  task automatic check_dst(input string tag, input int from);
    logic [15:0] e;
    for (int k = from; k < NUM_MSG; k++) begin
      e = model(src_lo[k], src_hi[k]);
      check($sformatf("%s_m%0d_lsw", tag, k), mem[DST_BASE + 2*k], e[7:0]);
      check($sformatf("%s_m%0d_msw", tag, k), mem[DST_BASE + 2*k + 1], e[15:8]);
    end
  endtask

  task automatic check_src(input string tag);
    for (int k = 0; k < NUM_MSG; k++) begin
      check($sformatf("%s_src%0d_lo", tag, k), mem[SRC_BASE + 2*k], src_lo[k]);
      check($sformatf("%s_src%0d_hi", tag, k), mem[SRC_BASE + 2*k + 1], src_hi[k]);
    end
  endtask

  // Pulse Start from IDLE/DONE and count edges, the sampling edge being 1,
  // until Ack is seen; optionally re-pulse Start mid-run.
  task automatic run(input int repulse_at, output int edges, output logic ack1);
    @(negedge Clk);
    Start = 1'b1;
    edges = 0;
    ack1  = 1'b1;
    do begin
      @(posedge Clk);
      edges++;
      #1;
      if (edges == 1) ack1 = Ack;
      Start = (edges == repulse_at);
    end while (!Ack && edges < BOUND);
    Start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    int   n;
    logic ack1;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'h07, 8'hFF, 8'hFF};
    vecs[2] = '{8'h01, 8'h00, 8'h0F, 8'h00};
    vecs[3] = '{8'h00, 8'h04, 8'h17, 8'h81};
    vecs[4] = '{8'h02, 8'h00, 8'h33, 8'h00};
    vecs[5] = '{8'h10, 8'h00, 8'h03, 8'h03};
    vecs[6] = '{8'h00, 8'hF8, 8'h00, 8'h00};

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ack", Ack, 0);
    check("rst_busy", Busy, 0);
    check("rst_wren", MemWrEn, 0);
    check("rst_addr", MemAddr, 0);
    check("rst_wdata", MemWrData, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Run 1: directed table plus random messages
    randomize_src();
    for (int k = 0; k < 7; k++) begin
      src_lo[k] = vecs[k].lo;
      src_hi[k] = vecs[k].hi;
    end
    load_src();
    fill_dst(8'hEE);
    run(0, edges, ack1);
    check("run1_ack_latency", edges, ACK_EDGES);
    check("run1_busy_done", Busy, 0);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("vec%0d_lsw", k), mem[DST_BASE + 2*k], vecs[k].exp_lo);
      check($sformatf("vec%0d_msw", k), mem[DST_BASE + 2*k + 1], vecs[k].exp_hi);
    end
    check_dst("run1", 7);
    check_src("run1");

    // Start after DONE: Ack drops on the accepting edge, new data encoded
    randomize_src();
    load_src();
    run(0, edges, ack1);
    check("redone_ack_drop", ack1, 0);
    check("redone_ack_latency", edges, ACK_EDGES);
    check_dst("redone", 0);

    // Start re-pulsed while busy is ignored
    randomize_src();
    load_src();
    run(10, edges, ack1);
    check("repulse10_latency", edges, ACK_EDGES);
    run(40, edges, ack1);
    check("repulse40_latency", edges, ACK_EDGES);
    check_dst("repulse", 0);

    // Asynchronous reset during WR_LO of message 7
    randomize_src();
    load_src();
    fill_dst(8'hEE);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    n = 0;
    while (!(MemWrEn && int'(MemAddr) == DST_BASE + 14) && n < BOUND) begin
      @(negedge Clk);
      n++;
    end
    check("abort_reached_wr_lo7", (n < BOUND), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_ack", Ack, 0);
    check("abort_busy", Busy, 0);
    check("abort_wren", MemWrEn, 0);
    check("abort_addr", MemAddr, 0);
    repeat (2) @(posedge Clk);
    check("abort_m7_lsw_unwritten", mem[DST_BASE + 14], 8'hEE);
    @(negedge Clk);
    Reset_n = 1'b1;
    fill_dst(8'hEE);
    run(0, edges, ack1);
    check("post_abort_latency", edges, ACK_EDGES);
    check_dst("post_abort", 0);

    // Start held high in DONE retriggers a run
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check("hold_first_busy", Busy, 1);
    n = 1;
    while (!Ack && n < BOUND) begin
      @(posedge Clk);
      n++;
      #1;
    end
    check("hold_ack_latency", n, ACK_EDGES);
    @(posedge Clk);
    #1;
    check("hold_retrig_ack", Ack, 0);
    check("hold_retrig_busy", Busy, 1);
    Start = 1'b0;
    n = 0;
    while (!Ack && n < BOUND) begin
      @(posedge Clk);
      n++;
      #1;
    end
    check("hold_second_done", Ack, 1);

`ifdef ERR_INJECT_EN
    // Error injection on an all-zero message
    src_lo[0] = 8'h00;
    src_hi[0] = 8'h00;
    load_byte(8'(SRC_BASE), 8'h00);
    load_byte(8'(SRC_BASE + 1), 8'h00);
    InjMask = 16'h0001;
    run(0, edges, ack1);
    InjMask = 16'h0000;
    check("inj0001_lsw", mem[DST_BASE], 8'h01);
    check("inj0001_msw", mem[DST_BASE + 1], 8'h00);
    InjMask = 16'h8001;
    run(0, edges, ack1);
    InjMask = 16'h0000;
    check("inj8001_lsw", mem[DST_BASE], 8'h01);
    check("inj8001_msw", mem[DST_BASE + 1], 8'h80);
`endif

    check("no_stray_writes", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
